reg_bank_mp: RTL and testbench



---
 rtl/reg_bank_pkg.sv | 14 +
 rtl/reg_bank_scoreboard.sv | 49 ++++
 rtl/reg_bank_mp.sv | 95 +++++++++
 tb/tb_reg_bank_mp.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared types and defaults for the multi-port register bank and its scoreboard.
package reg_bank_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned NREG_DEF = 32;

   function automatic int unsigned addr_width(input int unsigned nreg);
      return (nreg > 1) ? $clog2(nreg) : 1;
   endfunction

   typedef logic [addr_width(NREG_DEF)-1:0] reg_addr_t;
   typedef logic [XLEN_DEF-1:0]             xlen_t;

endpackage

// File: rtl/reg_bank_scoreboard.sv
// Per-register pending-write bits: set by load issue, cleared by load writeback.
module reg_bank_scoreboard
   import reg_bank_pkg::*;
#(
   parameter int NREG     = NREG_DEF,
   parameter int ZERO_REG = 1,
   localparam int AW      = addr_width(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pend_set_i,
   input  logic [AW-1:0]   pend_addr_i,
   input  logic            clr_en_i,
   input  logic [AW-1:0]   clr_addr_i,
   output logic [NREG-1:0] pending_o,
   output logic            pend_any_o
);

   logic [NREG-1:0] pending_q;
   logic [NREG-1:0] pending_d;

   // Set beats clear so back-to-back loads to one register stay pending.
   always_comb begin
      pending_d = pending_q;
      for (int i = 0; i < NREG; i++) begin
         if ((ZERO_REG != 0) && (i == 0)) begin
            pending_d[i] = 1'b0;
         end else if (pend_set_i && (pend_addr_i == AW'(i))) begin
            pending_d[i] = 1'b1;
         end else if (clr_en_i && (clr_addr_i == AW'(i))) begin
            pending_d[i] = 1'b0;
         end else begin
            pending_d[i] = pending_q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign pending_o  = pending_q;
   assign pend_any_o = |pending_q;

endmodule

// File: rtl/reg_bank_mp.sv
// Multi-port register bank: NRD combinational reads, ALU (A) and load (B) write
// ports, optional same-cycle bypass, hardwired x0 and a load-use scoreboard.
module reg_bank_mp
   import reg_bank_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREG     = NREG_DEF,
   parameter int NRD      = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = addr_width(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                wa_en,
   input  logic [AW-1:0]       wa_addr,
   input  logic [XLEN-1:0]     wa_data,
   input  logic                wb_en,
   input  logic [AW-1:0]       wb_addr,
   input  logic [XLEN-1:0]     wb_data,
   input  logic                pend_set,
   input  logic [AW-1:0]       pend_addr,
   output logic                pend_any
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NREG-1:0] pending_s;

   reg_bank_scoreboard #(
      .NREG     (NREG),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .pend_set_i  (pend_set),
      .pend_addr_i (pend_addr),
      .clr_en_i    (wb_en),
      .clr_addr_i  (wb_addr),
      .pending_o   (pending_s),
      .pend_any_o  (pend_any)
   );

   // Load writeback (B) takes priority over ALU writeback (A) on an address clash.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         if ((ZERO_REG != 0) && (i == 0)) begin
            regs_d[i] = '0;
         end else if (wb_en && (wb_addr == AW'(i))) begin
            regs_d[i] = wb_data;
         end else if (wa_en && (wa_addr == AW'(i))) begin
            regs_d[i] = wa_data;
         end else begin
            regs_d[i] = regs_q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Forwarded B data is the pending load completing, so busy drops with it.
   always_comb begin
      logic [AW-1:0] addr_v;
      rd_data = '0;
      rd_busy = '0;
      for (int p = 0; p < NRD; p++) begin
         addr_v = rd_addr[p*AW +: AW];
         if ((ZERO_REG != 0) && (addr_v == '0)) begin
            rd_data[p*XLEN +: XLEN] = '0;
            rd_busy[p]              = 1'b0;
         end else if ((BYPASS != 0) && wb_en && (wb_addr == addr_v)) begin
            rd_data[p*XLEN +: XLEN] = wb_data;
            rd_busy[p]              = 1'b0;
         end else if ((BYPASS != 0) && wa_en && (wa_addr == addr_v)) begin
            rd_data[p*XLEN +: XLEN] = wa_data;
            rd_busy[p]              = pending_s[addr_v];
         end else begin
            rd_data[p*XLEN +: XLEN] = regs_q[addr_v];
            rd_busy[p]              = pending_s[addr_v];
         end
      end
   end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Scoreboard-driven bench for reg_bank_mp (bypassing and non-bypassing instances).
module tb_reg_bank_mp;

   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [2*AW-1:0] rd_addr;
   logic [63:0]   rd_data, rd_data_nb;
   logic [1:0]    rd_busy, rd_busy_nb;
   logic          wa_en, wb_en, pend_set;
   logic [AW-1:0] wa_addr, wb_addr, pend_addr;
   logic [31:0]   wa_data, wb_data;
   logic          pend_any, pend_any_nb;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      string       tag;
      int          kind;
      logic [31:0] val;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   reg_bank_mp #(.BYPASS(1)) u_dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .pend_set(pend_set), .pend_addr(pend_addr), .pend_any(pend_any)
   );

   reg_bank_mp #(.BYPASS(0)) u_dut_nb (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
      .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .pend_set(pend_set), .pend_addr(pend_addr), .pend_any(pend_any_nb)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // kind: 0 rd_data[0], 1 rd_data[1], 2 rd_busy, 3 pend_any, 4 no-bypass rd_data[0]
   task automatic expect_out(input string tag, input int kind, input logic [31:0] val);
      exp_t e;
      e.tag  = tag;
      e.kind = kind;
      e.val  = val;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] obs;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         case (e.kind)
            0:       obs = rd_data[31:0];
            1:       obs = rd_data[63:32];
            2:       obs = {30'd0, rd_busy};
            3:       obs = {31'd0, pend_any};
            4:       obs = rd_data_nb[31:0];
            default: obs = 32'hxxxx_xxxx;
         endcase
         check_val(e.tag, obs, e.val);
      end
   endtask

   // Compare mid-cycle, then let the rising edge commit the driven inputs.
   task automatic cycle();
      @(negedge clk);
      drain();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; wa_en = 1'b0; wb_en = 1'b0; pend_set = 1'b0;
      wa_addr = 5'd0; wb_addr = 5'd0; pend_addr = 5'd0;
      wa_data = 32'd0; wb_data = 32'd0;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd_addr = {a1, a0};
   endtask

   task automatic write_a(input logic [AW-1:0] a, input logic [31:0] d);
      wa_en = 1'b1; wa_addr = a; wa_data = d;
   endtask

   task automatic write_b(input logic [AW-1:0] a, input logic [31:0] d);
      wb_en = 1'b1; wb_addr = a; wb_data = d;
   endtask

   initial begin
      idle();
      set_rd(5'd3, 5'd5);
      rst = 1'b1;
      cycle();

      idle(); set_rd(5'd3, 5'd5);
      expect_out("rst_rd0", 0, 32'd0);
      expect_out("rst_rd1", 1, 32'd0);
      expect_out("rst_busy", 2, 32'd0);
      expect_out("rst_pend_any", 3, 32'd0);
      cycle();

      write_a(5'd3, 32'hAAAA_1111); set_rd(5'd3, 5'd5);
      expect_out("byp_a_x3", 0, 32'hAAAA_1111);
      expect_out("nb_old_x3", 4, 32'd0);
      cycle();
      write_a(5'd5, 32'h1234_5678); cycle();
      write_a(5'd7, 32'hDEAD_BEEF); cycle();
      idle(); set_rd(5'd3, 5'd5);
      expect_out("rd_x3", 0, 32'hAAAA_1111);
      expect_out("rd_x5", 1, 32'h1234_5678);
      cycle();
      set_rd(5'd7, 5'd3);
      expect_out("rd_x7", 0, 32'hDEAD_BEEF);
      expect_out("rd_x3_p1", 1, 32'hAAAA_1111);
      cycle();

      write_a(5'd0, 32'hFFFF_FFFF); write_b(5'd0, 32'h1234_5678);
      pend_set = 1'b1; pend_addr = 5'd0; set_rd(5'd0, 5'd0);
      expect_out("x0_byp", 0, 32'd0);
      expect_out("x0_busy", 2, 32'd0);
      cycle();
      idle(); set_rd(5'd0, 5'd3);
      expect_out("x0_stored", 0, 32'd0);
      expect_out("x0_pend_any", 3, 32'd0);
      cycle();

      write_a(5'd9, 32'h1111_1111); write_b(5'd9, 32'h2222_2222); set_rd(5'd9, 5'd3);
      expect_out("clash_byp", 0, 32'h2222_2222);
      expect_out("clash_nb_old", 4, 32'd0);
      cycle();
      idle(); set_rd(5'd9, 5'd3);
      expect_out("clash_stored", 0, 32'h2222_2222);
      expect_out("clash_nb_stored", 4, 32'h2222_2222);
      cycle();

      pend_set = 1'b1; pend_addr = 5'd4; set_rd(5'd4, 5'd9);
      expect_out("pend_same_cyc", 2, 32'd0);
      expect_out("pend_any_pre", 3, 32'd0);
      cycle();
      idle(); set_rd(5'd4, 5'd9);
      expect_out("busy_x4", 2, 32'd1);
      expect_out("pend_any_x4", 3, 32'd1);
      cycle();
      write_a(5'd4, 32'h1111_0000); set_rd(5'd4, 5'd9);
      expect_out("a_keeps_busy", 2, 32'd1);
      expect_out("a_byp_x4", 0, 32'h1111_0000);
      cycle();
      idle(); write_b(5'd4, 32'hCAFE_F00D); set_rd(5'd4, 5'd9);
      expect_out("b_fwd_busy", 2, 32'd0);
      expect_out("b_fwd_data", 0, 32'hCAFE_F00D);
      expect_out("b_nb_old", 4, 32'h1111_0000);
      cycle();
      idle(); set_rd(5'd4, 5'd9);
      expect_out("b_cleared_any", 3, 32'd0);
      expect_out("b_stored", 0, 32'hCAFE_F00D);
      expect_out("b_cleared_busy", 2, 32'd0);
      cycle();
      pend_set = 1'b1; pend_addr = 5'd4; cycle();
      write_b(5'd4, 32'h0000_1234); set_rd(5'd9, 5'd4);
      expect_out("setclr_same_busy", 2, 32'd0);
      cycle();
      idle(); set_rd(5'd9, 5'd4);
      expect_out("set_wins_busy", 2, 32'd2);
      expect_out("set_wins_any", 3, 32'd1);
      cycle();

      write_b(5'd4, 32'h0000_0044); cycle();
      idle(); write_a(5'd6, 32'hBEEF_0001); pend_set = 1'b1; pend_addr = 5'd6; cycle();
      idle(); set_rd(5'd6, 5'd4);
      expect_out("x6_val", 0, 32'hBEEF_0001);
      expect_out("x6_busy", 2, 32'd1);
      cycle();
      rst = 1'b1; write_b(5'd6, 32'h5555_5555); write_a(5'd2, 32'h7777_7777);
      pend_set = 1'b1; pend_addr = 5'd3;
      cycle();
      idle(); set_rd(5'd6, 5'd9);
      expect_out("rst2_x6", 0, 32'd0);
      expect_out("rst2_x9", 1, 32'd0);
      expect_out("rst2_busy", 2, 32'd0);
      expect_out("rst2_any", 3, 32'd0);
      cycle();
      set_rd(5'd2, 5'd3);
      expect_out("rst2_x2", 0, 32'd0);
      expect_out("rst2_x3", 1, 32'd0);
      expect_out("rst2_busy_b", 2, 32'd0);
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
